// File: rtl/noc_ni_pkg.sv
// Shared types and constants for the mesh-tile network interface (package noc_pkg).
package noc_pkg;

    localparam int unsigned FLIT_W    = 18;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned COORD_W   = 2;
    localparam int unsigned FIFO_W    = 2 * COORD_W + 1 + DATA_W;

    // Flit field bit positions
    localparam int unsigned TYPE_MSB  = 17;
    localparam int unsigned TYPE_LSB  = 16;
    localparam int unsigned DST_X_LSB = 14;
    localparam int unsigned DST_Y_LSB = 12;
    localparam int unsigned SRC_X_LSB = 10;
    localparam int unsigned SRC_Y_LSB = 8;

    typedef enum logic [1:0] {
        FLIT_IDLE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e         ftype;
        logic [COORD_W-1:0] dst_x;
        logic [COORD_W-1:0] dst_y;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] src_y;
        logic [7:0]         rsvd;
    } head_flit_t;

    // One injection FIFO entry
    typedef struct packed {
        logic [COORD_W-1:0] dest_x;
        logic [COORD_W-1:0] dest_y;
        logic               last;
        logic [DATA_W-1:0]  data;
    } inj_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2
    } inj_state_e;

    // Body flit, or tail flit when the word closes its packet
    function automatic logic [FLIT_W-1:0] make_data_flit(input logic last,
                                                          input logic [DATA_W-1:0] data);
        flit_type_e ftype;
        ftype = last ? FLIT_TAIL : FLIT_BODY;
        return {ftype, data};
    endfunction

endpackage

// File: rtl/noc_ni_if.sv
// Core-side word streams and router local-port flit buses of one network interface.
interface noc_ni_if;
    import noc_pkg::*;

    logic                tx_valid;
    logic                tx_ready;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_last;
    logic [COORD_W-1:0]  tx_dest_x;
    logic [COORD_W-1:0]  tx_dest_y;
    logic [FLIT_W-1:0]   L_IN;
    logic                L_IN_READY;
    logic [FLIT_W-1:0]   L_OUT;
    logic                rx_valid;
    logic [DATA_W-1:0]   rx_data;
    logic                rx_last;
    logic [COORD_W-1:0]  rx_src_x;
    logic [COORD_W-1:0]  rx_src_y;
    logic                rx_err;

    // Network interface side
    modport slave (
        input  tx_valid, tx_data, tx_last, tx_dest_x, tx_dest_y, L_IN_READY, L_OUT,
        output tx_ready, L_IN, rx_valid, rx_data, rx_last, rx_src_x, rx_src_y, rx_err
    );

    // Core / router side
    modport master (
        output tx_valid, tx_data, tx_last, tx_dest_x, tx_dest_y, L_IN_READY, L_OUT,
        input  tx_ready, L_IN, rx_valid, rx_data, rx_last, rx_src_x, rx_src_y, rx_err
    );

endinterface

// File: rtl/noc_ni_fifo.sv
// Synchronous injection FIFO with full/empty flags; DEPTH must be a power of two.
module noc_ni_fifo #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/noc_ni.sv
// Mesh-tile network interface: packetises core words onto L_IN and reassembles L_OUT flits.
// Optional build macro NOC_NI_DEST_CHECK_EN: drop and flag received packets not addressed here.
module noc_ni
    import noc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] X_IN,
    input  logic [COORD_W-1:0] Y_IN,
    noc_ni_if.slave            bus
);

    // ---------------- injection side ----------------
    logic               r_in_reset;
    logic               r_first;
    logic [COORD_W-1:0] r_dest_x;
    logic [COORD_W-1:0] r_dest_y;
    inj_state_e         r_state;
    inj_state_e         w_state_next;
    logic [FLIT_W-1:0]  r_l_in;
    logic [FLIT_W-1:0]  w_l_in_next;

    logic               w_full;
    logic               w_empty;
    logic               w_tx_ready;
    logic               w_push;
    logic               w_pop;
    inj_entry_t         w_wentry;
    logic [FIFO_W-1:0]  w_rdata;
    inj_entry_t         w_front;
    head_flit_t         w_head;
    flit_type_e         w_l_in_type;
    logic               w_accept;

    assign w_tx_ready = !w_full && !r_in_reset;
    assign w_push     = bus.tx_valid && w_tx_ready;

    assign w_wentry.dest_x = r_first ? bus.tx_dest_x : r_dest_x;
    assign w_wentry.dest_y = r_first ? bus.tx_dest_y : r_dest_y;
    assign w_wentry.last   = bus.tx_last;
    assign w_wentry.data   = bus.tx_data;

    // Remember the packet destination from its first word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_reset <= 1'b1;
            r_first    <= 1'b1;
            r_dest_x   <= '0;
            r_dest_y   <= '0;
        end else begin
            r_in_reset <= 1'b0;
            if (w_push) begin
                r_first <= bus.tx_last;
                if (r_first) begin
                    r_dest_x <= bus.tx_dest_x;
                    r_dest_y <= bus.tx_dest_y;
                end
            end
        end
    end

    noc_ni_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_front = inj_entry_t'(w_rdata);

    // Head flit built from the oldest queued word's destination
    always_comb begin
        w_head       = '0;
        w_head.ftype = FLIT_HEAD;
        w_head.dst_x = w_front.dest_x;
        w_head.dst_y = w_front.dest_y;
        w_head.src_x = X_IN;
        w_head.src_y = Y_IN;
    end

    assign w_l_in_type = flit_type_e'(r_l_in[TYPE_MSB:TYPE_LSB]);
    assign w_accept    = (w_l_in_type != FLIT_IDLE) && bus.L_IN_READY;

    // Injection state and L_IN register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_l_in  <= '0;
        end else begin
            r_state <= w_state_next;
            r_l_in  <= w_l_in_next;
        end
    end

    // Injection next state, next flit and FIFO pop
    always_comb begin
        w_state_next = r_state;
        w_l_in_next  = r_l_in;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_l_in_next  = w_head;
                    w_state_next = HEAD;
                end
            end
            HEAD: begin
                if (w_accept) begin
                    if (!w_empty) begin
                        w_l_in_next = make_data_flit(w_front.last, w_front.data);
                        w_pop       = 1'b1;
                    end else begin
                        w_l_in_next = '0;
                    end
                    w_state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_accept && (w_l_in_type == FLIT_TAIL)) begin
                    w_l_in_next  = '0;
                    w_state_next = IDLE;
                end else if (w_accept || (w_l_in_type == FLIT_IDLE)) begin
                    // Slot free: send next word, or idle across an underflow gap
                    if (!w_empty) begin
                        w_l_in_next = make_data_flit(w_front.last, w_front.data);
                        w_pop       = 1'b1;
                    end else begin
                        w_l_in_next = '0;
                    end
                end
            end
            default: begin
                w_l_in_next  = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.L_IN     = r_l_in;
    assign bus.tx_ready = w_tx_ready;

    // ---------------- ejection side ----------------
    flit_type_e         w_rx_type;
    logic               w_dst_mismatch;
    logic               r_in_pkt;
    logic               r_drop;
    logic               r_rx_valid;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_last;
    logic [COORD_W-1:0] r_rx_src_x;
    logic [COORD_W-1:0] r_rx_src_y;
    logic               r_rx_err;

    assign w_rx_type = flit_type_e'(bus.L_OUT[TYPE_MSB:TYPE_LSB]);

`ifdef NOC_NI_DEST_CHECK_EN
    assign w_dst_mismatch = (bus.L_OUT[DST_X_LSB +: COORD_W] != X_IN) ||
                            (bus.L_OUT[DST_Y_LSB +: COORD_W] != Y_IN);
`else
    assign w_dst_mismatch = 1'b0;
`endif

    // Reassemble incoming flits into single-cycle word pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_pkt   <= 1'b0;
            r_drop     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_last  <= 1'b0;
            r_rx_src_x <= '0;
            r_rx_src_y <= '0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            case (w_rx_type)
                FLIT_HEAD: begin
                    if (r_in_pkt || w_dst_mismatch) r_rx_err <= 1'b1;
                    r_rx_src_x <= bus.L_OUT[SRC_X_LSB +: COORD_W];
                    r_rx_src_y <= bus.L_OUT[SRC_Y_LSB +: COORD_W];
                    r_in_pkt   <= 1'b1;
                    r_drop     <= w_dst_mismatch;
                end
                FLIT_BODY, FLIT_TAIL: begin
                    if (!r_in_pkt) begin
                        r_rx_err <= 1'b1;
                    end else begin
                        if (!r_drop) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= bus.L_OUT[DATA_W-1:0];
                            r_rx_last  <= (w_rx_type == FLIT_TAIL);
                        end
                        if (w_rx_type == FLIT_TAIL) begin
                            r_in_pkt <= 1'b0;
                            r_drop   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_last  = r_rx_last;
    assign bus.rx_src_x = r_rx_src_x;
    assign bus.rx_src_y = r_rx_src_y;
    assign bus.rx_err   = r_rx_err;

endmodule
